chunk_adder_seq: RTL and testbench
==================================

CHUNK_ADDER_SEQ -- requirements
Module: chunk_adder_seq

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL provide parameter CHUNK, default 8, bits added per cycle; WIDTH SHALL be an integer multiple of CHUNK; NCHUNK = WIDTH/CHUNK.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 sub  input  1  0 = add, 1 = subtract (a - b).
REQ-007 a  input  WIDTH  operand A, sampled with start.
REQ-008 b  input  WIDTH  operand B, sampled with start.
REQ-009 cin  input  1  carry-in for add; ignored when sub=1.
REQ-010 s  output  WIDTH  sum/difference.
REQ-011 cout  output  1  carry out of bit WIDTH-1 (for sub: 1 = no borrow).
REQ-012 ovf  output  1  two's-complement signed overflow.
REQ-013 busy  output  1  high while in RUN.
REQ-014 done  output  1  one-cycle pulse: s/cout/ovf valid.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE; IDLE->RUN on start=1; RUN->DONE after NCHUNK RUN cycles; DONE->IDLE unconditionally after one cycle.
REQ-016 On the edge accepting start, SHALL capture a, b_eff = sub ? ~b : b, carry = sub ? 1 : cin, clear chunk counter to 0.
REQ-017 Each RUN cycle SHALL add chunk k (bits k*CHUNK+CHUNK-1 .. k*CHUNK) of a and b_eff plus stored carry, write that slice of s, store chunk carry-out, increment k; chunks processed LSB-first.
REQ-018 Latency: start sampled at edge E0; chunks written at edges E1..E_NCHUNK; done=1 for exactly the cycle following E_NCHUNK (4 RUN cycles, done after E4 for defaults).
REQ-019 cout SHALL equal final stored carry; ovf SHALL equal (a[MSB] == b_eff[MSB]) && (s[MSB] != a[MSB]); both valid when done=1.
REQ-020 s, cout, ovf SHALL hold their values from DONE until the next accepted start; s SHALL not be cleared at start but partially overwritten chunk by chunk (intermediate values unspecified to consumers).
REQ-021 start while in RUN or DONE SHALL be ignored and SHALL NOT alter captured operands.
REQ-022 start held high continuously SHALL begin a new operation on the first IDLE cycle after DONE.
REQ-023 CHUNK = WIDTH (NCHUNK=1) SHALL be legal: one RUN cycle then DONE.
REQ-024 Chunk counter SHALL be sized ceil(log2(NCHUNK+1)) bits and SHALL NOT wrap within an operation.

Reset
REQ-025 rst=1 SHALL asynchronously force state IDLE, s=0, cout=0, ovf=0, busy=0, done=0, counter=0, stored carry=0.
REQ-026 rst asserted during RUN or DONE SHALL abort the operation with no done pulse; first start after rst deasserts SHALL behave as from power-up.

Structure
REQ-027 FSM state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) SHALL live in the shared adder package/include alongside default WIDTH/CHUNK constants.
REQ-028 SHALL instantiate one combinational sub-module rca_chunk (parameter N=CHUNK; ports sum, carry-out, a, b, carry-in), a ripple-carry adder built from full-adder cells.
REQ-029 Operand registers SHALL be right-shifted or indexed by counter; no WIDTH-wide combinational adder SHALL exist in the block.

Verification
REQ-030 Add: a=32'd10, b=32'd20, cin=0, sub=0 -> done after 4 RUN cycles, s=32'd30, cout=0, ovf=0.
REQ-031 Carry wrap: a=32'hffffffff, b=32'h3 -> s=32'h2, cout=1, ovf=0; a=32'hffff0000, b=32'h205da -> s=32'h105da, cout=1.
REQ-032 Cross-chunk carry: a=32'he3244bbe, b=32'hd332ff2 -> s=32'hf0577bb0, cout=0; a=32'h7fffffff, b=32'h1 -> s=32'h80000000, ovf=1, cout=0.
REQ-033 Subtract: a=32'd5, b=32'd7, sub=1, cin=1 -> s=32'hfffffffe, cout=0, ovf=0; a=32'd7, b=32'd5 -> s=32'd2, cout=1.
REQ-034 Start during RUN with different operands -> ignored, first result unchanged; rst pulsed at second RUN cycle -> no done, all outputs 0, next start yields correct result.
REQ-035 Parameter sweep: WIDTH=32 with CHUNK=32, 4, 1 and WIDTH=16/CHUNK=8 -> results match a+b+cin reference; done latency = NCHUNK+1 cycles after start edge.

Source files
------------

// File: rtl/chunk_adder_seq_pkg.sv
// Shared definitions for the chunk-serial adder: FSM encoding and default sizes.
package chunk_adder_seq_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_CHUNK = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/chunk_adder_seq_rca_chunk.sv
// Combinational N-bit ripple-carry adder built from full-adder cells.
module rca_chunk
  import chunk_adder_seq_pkg::*;
#(
  parameter int unsigned N = DEF_CHUNK
) (
  output logic [N-1:0] sum,
  output logic         cout,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin
);

  logic [N:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[N];

endmodule

// File: rtl/chunk_adder_seq.sv
// Sequential adder/subtractor: one CHUNK-bit slice per cycle, LSB first,
// through a single shared ripple-carry chunk adder.
module chunk_adder_seq
  import chunk_adder_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned CW     = $clog2(NCHUNK + 1);
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  if (WIDTH % CHUNK != 0) begin : g_bad_cfg
    $error("chunk_adder_seq: WIDTH must be a multiple of CHUNK");
  end

  state_t state, state_nx;

  logic [WIDTH-1:0] a_r, b_r, s_r;
  logic             carry;
  logic [CW-1:0]    k;
  logic             cout_r, ovf_r;
  logic             accept, last;
  logic [CHUNK-1:0] a_ch, b_ch, sum_ch;
  logic             c_ch;

  // Operand slices are selected by the counter, so operands stay intact for ovf.
  always_comb begin
    a_ch = '0;
    b_ch = '0;
    for (int unsigned i = 0; i < NCHUNK; i++) begin
      if (k == CW'(i)) begin
        a_ch = a_r[i*CHUNK +: CHUNK];
        b_ch = b_r[i*CHUNK +: CHUNK];
      end
    end
  end

  rca_chunk #(.N(CHUNK)) u_rca (
    .sum  (sum_ch),
    .cout (c_ch),
    .a    (a_ch),
    .b    (b_ch),
    .cin  (carry)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    accept   = 1'b0;
    last     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (k == LAST) begin
          last     = 1'b1;
          state_nx = DONE;
        end
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r    <= '0;
      b_r    <= '0;
      s_r    <= '0;
      carry  <= 1'b0;
      k      <= '0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else if (accept) begin
      a_r   <= a;
      b_r   <= sub ? ~b : b;
      carry <= sub ? 1'b1 : cin;
      k     <= '0;
    end else if (state == RUN) begin
      for (int unsigned i = 0; i < NCHUNK; i++) begin
        if (k == CW'(i)) s_r[i*CHUNK +: CHUNK] <= sum_ch;
      end
      carry <= c_ch;
      k     <= k + CW'(1);
      // Final chunk carries the MSB, so flags are resolved here and then held.
      if (last) begin
        cout_r <= c_ch;
        ovf_r  <= (a_r[WIDTH-1] == b_r[WIDTH-1]) && (sum_ch[CHUNK-1] != a_r[WIDTH-1]);
      end
    end
  end

  assign s    = s_r;
  assign cout = cout_r;
  assign ovf  = ovf_r;

endmodule

// File: tb/tb_chunk_adder_seq.sv
// Scoreboard bench for chunk_adder_seq: default instance plus a parameter sweep.
module tb_chunk_adder_seq;

  localparam int LIMIT = 60;

  typedef struct {
    logic [31:0] s;
    logic        cout;
    logic        ovf;
    int          lat;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_m = 1'b0, start_s = 1'b0;
  logic        sub = 1'b0, cin = 1'b0;
  logic [31:0] a = '0, b = '0;

  logic [31:0] s_m, s_32, s_4, s_1;
  logic [15:0] s_16;
  logic        cout_m, ovf_m, busy_m, done_m;
  logic        cout_32, ovf_32, busy_32, done_32;
  logic        cout_4, ovf_4, busy_4, done_4;
  logic        cout_1, ovf_1, busy_1, done_1;
  logic        cout_16, ovf_16, busy_16, done_16;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  chunk_adder_seq #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .rst(rst), .start(start_m), .sub(sub), .a(a), .b(b), .cin(cin),
    .s(s_m), .cout(cout_m), .ovf(ovf_m), .busy(busy_m), .done(done_m));

  chunk_adder_seq #(.WIDTH(32), .CHUNK(32)) dut_c32 (
    .clk(clk), .rst(rst), .start(start_s), .sub(sub), .a(a), .b(b), .cin(cin),
    .s(s_32), .cout(cout_32), .ovf(ovf_32), .busy(busy_32), .done(done_32));

  chunk_adder_seq #(.WIDTH(32), .CHUNK(4)) dut_c4 (
    .clk(clk), .rst(rst), .start(start_s), .sub(sub), .a(a), .b(b), .cin(cin),
    .s(s_4), .cout(cout_4), .ovf(ovf_4), .busy(busy_4), .done(done_4));

  chunk_adder_seq #(.WIDTH(32), .CHUNK(1)) dut_c1 (
    .clk(clk), .rst(rst), .start(start_s), .sub(sub), .a(a), .b(b), .cin(cin),
    .s(s_1), .cout(cout_1), .ovf(ovf_1), .busy(busy_1), .done(done_1));

  chunk_adder_seq #(.WIDTH(16), .CHUNK(8)) dut_w16 (
    .clk(clk), .rst(rst), .start(start_s), .sub(sub), .a(a[15:0]), .b(b[15:0]), .cin(cin),
    .s(s_16), .cout(cout_16), .ovf(ovf_16), .busy(busy_16), .done(done_16));

  // Reference: plain wide add of a, b_eff and the effective carry-in.
  function automatic exp_t model(input logic [31:0] aa, input logic [31:0] bb,
                                 input logic c, input logic sb, input int w, input int lat);
    exp_t        e;
    logic [32:0] t;
    logic [31:0] be, mask, am;
    logic        ci;
    be   = sb ? ~bb : bb;
    ci   = sb ? 1'b1 : c;
    mask = (w == 32) ? 32'hffff_ffff : ((32'd1 << w) - 32'd1);
    am   = aa & mask;
    be   = be & mask;
    t    = {1'b0, am} + {1'b0, be} + {32'd0, ci};
    e.s    = t[31:0] & mask;
    e.cout = t[w];
    e.ovf  = (am[w-1] == be[w-1]) && (e.s[w-1] != am[w-1]);
    e.lat  = lat;
    return e;
  endfunction

  task automatic pulse_start_m(input logic [31:0] aa, input logic [31:0] bb,
                               input logic c, input logic sb);
    @(negedge clk);
    a = aa; b = bb; cin = c; sub = sb; start_m = 1'b1;
    @(negedge clk);
    start_m = 1'b0;
  endtask

  task automatic wait_done_m(input int lat0, output int lat);
    lat = lat0;
    while (done_m !== 1'b1 && lat < LIMIT) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if ({s_m, cout_m, ovf_m, busy_m, done_m} !== 36'd0) begin
      fails++;
      $display("FAIL reset_state: got s=%h cout=%b ovf=%b busy=%b done=%b, want all 0",
               s_m, cout_m, ovf_m, busy_m, done_m);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if ({busy_m, done_m, s_m} !== 34'd0) begin
      fails++;
      $display("FAIL reset_idle: got busy=%b done=%b s=%h, want 0", busy_m, done_m, s_m);
    end
  endtask

  task automatic test_add();
    vec_t v[9];
    exp_t e;
    int   lat;
    v[0] = '{32'd10,        32'd20,        1'b0, 1'b0};
    v[1] = '{32'hffffffff,  32'h3,         1'b0, 1'b0};
    v[2] = '{32'hffff0000,  32'h205da,     1'b0, 1'b0};
    v[3] = '{32'he3244bbe,  32'hd332ff2,   1'b0, 1'b0};
    v[4] = '{32'h7fffffff,  32'h1,         1'b0, 1'b0};
    v[5] = '{32'd5,         32'd7,         1'b1, 1'b1};
    v[6] = '{32'd7,         32'd5,         1'b1, 1'b1};
    v[7] = '{32'h12345678,  32'h0edcba98,  1'b1, 1'b0};
    v[8] = '{32'h80000000,  32'h1,         1'b0, 1'b1};
    foreach (v[i]) begin
      pulse_start_m(v[i].a, v[i].b, v[i].cin, v[i].sub);
      exp_q.push_back(model(v[i].a, v[i].b, v[i].cin, v[i].sub, 32, 5));
      tests++;
      if (busy_m !== 1'b1) begin
        fails++;
        $display("FAIL add[%0d] busy: got %b, want 1", i, busy_m);
      end
      wait_done_m(1, lat);
      e = exp_q.pop_front();
      tests++;
      if (done_m !== 1'b1 || lat != e.lat || s_m !== e.s || cout_m !== e.cout || ovf_m !== e.ovf) begin
        fails++;
        $display("FAIL add[%0d] result: got done=%b s=%h cout=%b ovf=%b lat=%0d, want s=%h cout=%b ovf=%b lat=%0d",
                 i, done_m, s_m, cout_m, ovf_m, lat, e.s, e.cout, e.ovf, e.lat);
      end
      @(negedge clk);
      tests++;
      if (done_m !== 1'b0 || s_m !== e.s || cout_m !== e.cout || ovf_m !== e.ovf) begin
        fails++;
        $display("FAIL add[%0d] hold: got done=%b s=%h cout=%b ovf=%b, want done=0 s=%h cout=%b ovf=%b",
                 i, done_m, s_m, cout_m, ovf_m, e.s, e.cout, e.ovf);
      end
    end
  endtask

  task automatic test_ignore_start();
    exp_t e;
    int   lat;
    pulse_start_m(32'h0000_1111, 32'h0000_2222, 1'b0, 1'b0);
    exp_q.push_back(model(32'h0000_1111, 32'h0000_2222, 1'b0, 1'b0, 32, 5));
    @(negedge clk);
    a = 32'hdead_beef; b = 32'h1234_0000; sub = 1'b1; start_m = 1'b1;
    @(negedge clk);
    start_m = 1'b0;
    wait_done_m(3, lat);
    e = exp_q.pop_front();
    tests++;
    if (done_m !== 1'b1 || lat != e.lat || s_m !== e.s || cout_m !== e.cout || ovf_m !== e.ovf) begin
      fails++;
      $display("FAIL ignore_start: got done=%b s=%h cout=%b ovf=%b lat=%0d, want s=%h cout=%b ovf=%b lat=%0d",
               done_m, s_m, cout_m, ovf_m, lat, e.s, e.cout, e.ovf, e.lat);
    end
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (busy_m !== 1'b0 || done_m !== 1'b0) begin
      fails++;
      $display("FAIL ignore_start_idle: got busy=%b done=%b, want 0 0", busy_m, done_m);
    end
  endtask

  task automatic test_rst_abort();
    exp_t e;
    int   lat;
    int   seen;
    pulse_start_m(32'h0f0f_0f0f, 32'h0101_0101, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests++;
    if ({s_m, cout_m, ovf_m, busy_m, done_m} !== 36'd0) begin
      fails++;
      $display("FAIL rst_abort_clear: got s=%h cout=%b ovf=%b busy=%b done=%b, want all 0",
               s_m, cout_m, ovf_m, busy_m, done_m);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done_m !== 1'b0 || busy_m !== 1'b0) seen++;
    end
    tests++;
    if (seen != 0) begin
      fails++;
      $display("FAIL rst_abort_quiet: got %0d active cycles, want 0", seen);
    end
    pulse_start_m(32'h8000_0001, 32'h8000_0001, 1'b0, 1'b0);
    exp_q.push_back(model(32'h8000_0001, 32'h8000_0001, 1'b0, 1'b0, 32, 5));
    wait_done_m(1, lat);
    e = exp_q.pop_front();
    tests++;
    if (done_m !== 1'b1 || lat != e.lat || s_m !== e.s || cout_m !== e.cout || ovf_m !== e.ovf) begin
      fails++;
      $display("FAIL rst_abort_next: got done=%b s=%h cout=%b ovf=%b lat=%0d, want s=%h cout=%b ovf=%b lat=%0d",
               done_m, s_m, cout_m, ovf_m, lat, e.s, e.cout, e.ovf, e.lat);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   lat;
    @(negedge clk);
    a = 32'h00ff_00ff; b = 32'h0001_0001; cin = 1'b0; sub = 1'b0; start_m = 1'b1;
    exp_q.push_back(model(32'h00ff_00ff, 32'h0001_0001, 1'b0, 1'b0, 32, 5));
    @(negedge clk);
    wait_done_m(1, lat);
    e = exp_q.pop_front();
    tests++;
    if (done_m !== 1'b1 || lat != e.lat || s_m !== e.s || cout_m !== e.cout || ovf_m !== e.ovf) begin
      fails++;
      $display("FAIL b2b_first: got done=%b s=%h cout=%b ovf=%b lat=%0d, want s=%h cout=%b ovf=%b lat=%0d",
               done_m, s_m, cout_m, ovf_m, lat, e.s, e.cout, e.ovf, e.lat);
    end
    a = 32'h0000_0003; b = 32'h0000_0009; sub = 1'b1;
    exp_q.push_back(model(32'h0000_0003, 32'h0000_0009, 1'b0, 1'b1, 32, 5));
    @(negedge clk);
    tests++;
    if (busy_m !== 1'b0 || done_m !== 1'b0) begin
      fails++;
      $display("FAIL b2b_idle_gap: got busy=%b done=%b, want 0 0", busy_m, done_m);
    end
    @(negedge clk);
    start_m = 1'b0;
    tests++;
    if (busy_m !== 1'b1) begin
      fails++;
      $display("FAIL b2b_restart: got busy=%b, want 1", busy_m);
    end
    wait_done_m(1, lat);
    e = exp_q.pop_front();
    tests++;
    if (done_m !== 1'b1 || lat != e.lat || s_m !== e.s || cout_m !== e.cout || ovf_m !== e.ovf) begin
      fails++;
      $display("FAIL b2b_second: got done=%b s=%h cout=%b ovf=%b lat=%0d, want s=%h cout=%b ovf=%b lat=%0d",
               done_m, s_m, cout_m, ovf_m, lat, e.s, e.cout, e.ovf, e.lat);
    end
  endtask

  task automatic test_sweep();
    vec_t        v[6];
    exp_t        e;
    logic [31:0] gs[4];
    logic        gc[4], go[4];
    int          gl[4];
    bit          seen[4];
    logic [3:0]  dn;
    int          lat;
    v[0] = '{32'd10,       32'd20,       1'b0, 1'b0};
    v[1] = '{32'hffffffff, 32'h3,        1'b0, 1'b0};
    v[2] = '{32'h7fff7fff, 32'h00010001, 1'b0, 1'b0};
    v[3] = '{32'd5,        32'd7,        1'b0, 1'b1};
    v[4] = '{$urandom,     $urandom,     1'b1, 1'b0};
    v[5] = '{$urandom,     $urandom,     1'b0, 1'b1};
    foreach (v[i]) begin
      @(negedge clk);
      a = v[i].a; b = v[i].b; cin = v[i].cin; sub = v[i].sub; start_s = 1'b1;
      exp_q.push_back(model(v[i].a, v[i].b, v[i].cin, v[i].sub, 32, 2));
      exp_q.push_back(model(v[i].a, v[i].b, v[i].cin, v[i].sub, 32, 9));
      exp_q.push_back(model(v[i].a, v[i].b, v[i].cin, v[i].sub, 32, 33));
      exp_q.push_back(model(v[i].a, v[i].b, v[i].cin, v[i].sub, 16, 3));
      @(negedge clk);
      start_s = 1'b0;
      tests++;
      if ({busy_32, busy_4, busy_1, busy_16} !== 4'b1111) begin
        fails++;
        $display("FAIL sweep[%0d] busy: got %b, want 1111", i, {busy_32, busy_4, busy_1, busy_16});
      end
      seen = '{default: 1'b0};
      gl   = '{default: 0};
      lat  = 1;
      forever begin
        dn = {done_16, done_1, done_4, done_32};
        if (!seen[0] && dn[0] === 1'b1) begin seen[0] = 1; gs[0] = s_32; gc[0] = cout_32; go[0] = ovf_32; gl[0] = lat; end
        if (!seen[1] && dn[1] === 1'b1) begin seen[1] = 1; gs[1] = s_4;  gc[1] = cout_4;  go[1] = ovf_4;  gl[1] = lat; end
        if (!seen[2] && dn[2] === 1'b1) begin seen[2] = 1; gs[2] = s_1;  gc[2] = cout_1;  go[2] = ovf_1;  gl[2] = lat; end
        if (!seen[3] && dn[3] === 1'b1) begin seen[3] = 1; gs[3] = {16'd0, s_16}; gc[3] = cout_16; go[3] = ovf_16; gl[3] = lat; end
        if ((seen[0] && seen[1] && seen[2] && seen[3]) || lat >= LIMIT) break;
        @(negedge clk);
        lat++;
      end
      for (int j = 0; j < 4; j++) begin
        e = exp_q.pop_front();
        tests++;
        if (!seen[j] || gl[j] != e.lat || gs[j] !== e.s || gc[j] !== e.cout || go[j] !== e.ovf) begin
          fails++;
          $display("FAIL sweep[%0d] inst%0d: got seen=%0d s=%h cout=%b ovf=%b lat=%0d, want s=%h cout=%b ovf=%b lat=%0d",
                   i, j, seen[j], gs[j], gc[j], go[j], gl[j], e.s, e.cout, e.ovf, e.lat);
        end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_ignore_start();
    test_rst_abort();
    test_back_to_back();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
